// File: rtl/column_window_sequencer_if.sv
// Column stream interface for the window sequencer. The producer side drives
// the incoming column stream, and the sequencer returns the column pair that the
// moment accumulators consume.
interface column_window_sequencer_if #(
    parameter int LUMA_BITS      = 8,
    parameter int WINDOW_SIZE_Y  = 5,
    parameter int MAX_LINE_WIDTH = 1024
);
    localparam int COL_W = LUMA_BITS * WINDOW_SIZE_Y;
    localparam int CW    = $clog2(MAX_LINE_WIDTH);

    logic             in_line_start;
    logic             in_valid;
    logic [COL_W-1:0] in_column;

    logic             out_valid;
    logic             out_reset;
    logic [COL_W-1:0] out_column;
    logic [COL_W-1:0] out_peek_column;
    logic             out_window_full;
    logic [CW-1:0]    out_col_index;
    logic             out_overflow;

    modport master (
        output in_line_start, in_valid, in_column,
        input  out_valid, out_reset, out_column, out_peek_column,
               out_window_full, out_col_index, out_overflow
    );

    modport slave (
        input  in_line_start, in_valid, in_column,
        output out_valid, out_reset, out_column, out_peek_column,
               out_window_full, out_col_index, out_overflow
    );
endinterface

// File: rtl/column_window_sequencer.sv
// Column window sequencer. The block keeps the last WINDOW_SIZE_X valid columns
// of a line in a ring buffer. For every valid column it emits the entering column
// and the column that leaves the window ("peek"). The peek reads as zero while the
// window is still filling. The first column of each line carries out_reset.
module column_window_sequencer #(
    parameter int LUMA_BITS      = 8,
    parameter int WINDOW_SIZE_X  = 7,
    parameter int WINDOW_SIZE_Y  = 5,
    parameter int MAX_LINE_WIDTH = 1024
) (
    input logic                     clk,
    input logic                     in_reset_n,
    column_window_sequencer_if.slave bus
);
    localparam int COL_W = LUMA_BITS * WINDOW_SIZE_Y;
    localparam int CW    = $clog2(MAX_LINE_WIDTH);
    localparam int PW    = $clog2(WINDOW_SIZE_X);
    localparam int FW    = $clog2(WINDOW_SIZE_X + 1);

    localparam logic [PW-1:0] PTR_LAST  = PW'(WINDOW_SIZE_X - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(WINDOW_SIZE_X);
    localparam logic [CW-1:0] IDX_LAST  = CW'(MAX_LINE_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STEADY
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             pend_q, pend_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             reset_q, reset_d;
    logic             full_q, full_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [COL_W-1:0] peek_q, peek_d;

    logic             ring_we;
    logic [PW-1:0]    ring_waddr;
    logic [COL_W-1:0] ring [WINDOW_SIZE_X];

    // Next-state, ring write and output decode for one input cycle.
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        reset_d    = 1'b0;
        full_d     = full_q;
        col_d      = col_q;
        peek_d     = peek_q;
        ring_we    = 1'b0;
        ring_waddr = wr_ptr_q;

        if (bus.in_valid) begin
            if (bus.in_line_start || pend_q) begin
                // A new line discards the old window. Stale ring entries are
                // masked by the zero peek until the window refills.
                ring_we    = 1'b1;
                ring_waddr = '0;
                wr_ptr_d   = PW'(1);
                fill_d     = FW'(1);
                idx_d      = '0;
                pend_d     = 1'b0;
                valid_d    = 1'b1;
                reset_d    = 1'b1;
                full_d     = 1'b0;
                col_d      = bus.in_column;
                peek_d     = '0;
                state_d    = FILL;
            end else if (state_q != IDLE) begin
                ring_we  = 1'b1;
                valid_d  = 1'b1;
                col_d    = bus.in_column;
                // The slot about to be overwritten holds the column leaving the window.
                peek_d   = (fill_q == FILL_FULL) ? ring[wr_ptr_q] : '0;
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
                if (fill_q != FILL_FULL) begin
                    fill_d = fill_q + FW'(1);
                end
                full_d = (fill_d == FILL_FULL);
                if (idx_q == IDX_LAST) begin
                    ovf_d = 1'b1;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
                if (fill_d == FILL_FULL) begin
                    state_d = STEADY;
                end
            end
        end else if (bus.in_line_start) begin
            // Remember the line start until the next valid column arrives.
            pend_d = 1'b1;
        end
    end

    // Control state and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            reset_q  <= 1'b0;
            full_q   <= 1'b0;
            col_q    <= '0;
            peek_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            reset_q  <= reset_d;
            full_q   <= full_d;
            col_q    <= col_d;
            peek_q   <= peek_d;
        end
    end

    // Column ring storage.
    // NOTE: the ring has no reset. Its contents are never observed before they are written, because the peek is gated by fill.
    always_ff @(posedge clk) begin
        if (ring_we) begin
            ring[ring_waddr] <= bus.in_column;
        end
    end

    assign bus.out_valid       = valid_q;
    assign bus.out_reset       = reset_q;
    assign bus.out_column      = col_q;
    assign bus.out_peek_column = peek_q;
    assign bus.out_window_full = full_q;
    assign bus.out_col_index   = idx_q;
    assign bus.out_overflow    = ovf_q;
endmodule

// File: tb/tb_column_window_sequencer.sv
// Directed bench for column_window_sequencer. Window width is 7 and column height is 5.
// The maximum line width is 16, so index saturation is reachable.
module tb_column_window_sequencer;
    localparam int LB    = 8;
    localparam int WX    = 7;
    localparam int WY    = 5;
    localparam int MW    = 16;
    localparam int CW    = $clog2(MW);
    localparam int COL_W = LB * WY;

    typedef struct {
        logic          ls;
        logic          v;
        logic [7:0]    b;
        logic          ev;
        logic          er;
        logic [7:0]    ep;
        logic          ef;
        logic [CW-1:0] ei;
        logic          eo;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    column_window_sequencer_if #(.LUMA_BITS(LB), .WINDOW_SIZE_Y(WY), .MAX_LINE_WIDTH(MW)) bus ();

    column_window_sequencer #(
        .LUMA_BITS(LB), .WINDOW_SIZE_X(WX), .WINDOW_SIZE_Y(WY), .MAX_LINE_WIDTH(MW)
    ) dut (
        .clk       (clk),
        .in_reset_n(rst_n),
        .bus       (bus)
    );

    function automatic logic [COL_W-1:0] rep(input logic [7:0] b);
        return {WY{b}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic add_valid(input logic ls, input logic [7:0] b, input logic er,
                             input logic [7:0] ep, input logic ef, input int ei, input logic eo);
        vec_t t;
        t.ls = ls; t.v = 1'b1; t.b = b; t.ev = 1'b1; t.er = er;
        t.ep = ep; t.ef = ef; t.ei = CW'(ei); t.eo = eo;
        vecs.push_back(t);
    endtask

    task automatic add_gap(input logic ls, input logic v);
        vec_t t;
        t.ls = ls; t.v = v; t.b = 8'hEE; t.ev = 1'b0; t.er = 1'b0;
        t.ep = 8'h00; t.ef = 1'b0; t.ei = '0; t.eo = 1'b0;
        vecs.push_back(t);
    endtask

    task automatic step(input logic ls, input logic v, input logic [7:0] b);
        bus.in_line_start = ls;
        bus.in_valid      = v;
        bus.in_column     = rep(b);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, " reset"}, 64'(bus.out_reset), 64'd0);
        check({tag, " col"},   64'(bus.out_column), 64'd0);
        check({tag, " peek"},  64'(bus.out_peek_column), 64'd0);
        check({tag, " full"},  64'(bus.out_window_full), 64'd0);
        check({tag, " idx"},   64'(bus.out_col_index), 64'd0);
        check({tag, " ovf"},   64'(bus.out_overflow), 64'd0);
    endtask

    initial begin
        int k;

        // Columns arriving before any line start are dropped.
        add_gap(1'b0, 1'b1);
        add_gap(1'b0, 1'b1);

        // Fill, then steady state: column n carries pixels n+1.
        for (int n = 0; n < 10; n++) begin
            add_valid(n == 0, 8'(n + 1), n == 0, (n >= 7) ? 8'(n - 6) : 8'h00, n >= 6, n, 1'b0);
        end

        // The same stream with invalid gaps at input cycles 3, 7 and 11.
        k = 0;
        for (int c = 0; c < 13; c++) begin
            if (c == 3 || c == 7 || c == 11) begin
                add_gap(1'b0, 1'b0);
            end else begin
                add_valid(k == 0, 8'(k + 1), k == 0, (k >= 7) ? 8'(k - 6) : 8'h00, k >= 6, k, 1'b0);
                k++;
            end
        end

        // Deferred line start: pulse without valid, two idle cycles, then 0x22.
        add_gap(1'b1, 1'b0);
        add_gap(1'b0, 1'b0);
        add_gap(1'b0, 1'b0);
        add_valid(1'b0, 8'h22, 1'b1, 8'h00, 1'b0, 0, 1'b0);
        for (int j = 1; j <= 8; j++) begin
            add_valid(1'b0, 8'(8'h30 + j), 1'b0,
                      (j == 7) ? 8'h22 : (j == 8) ? 8'h31 : 8'h00, j >= 6, j, 1'b0);
        end

        // A line change in steady state: the stale window stays masked until it refills.
        add_valid(1'b1, 8'hAA, 1'b1, 8'h00, 1'b0, 0, 1'b0);
        for (int j = 1; j <= 7; j++) begin
            add_valid(1'b0, 8'(8'hB0 + j), 1'b0, (j == 7) ? 8'hAA : 8'h00, j >= 6, j, 1'b0);
        end

        // Overflow: 17 columns in a 16-wide line. The flag survives the next line start.
        for (int n = 0; n < 17; n++) begin
            add_valid(n == 0, 8'(8'h40 + n), n == 0, (n >= 7) ? 8'(8'h40 + n - 7) : 8'h00,
                      n >= 6, (n > 15) ? 15 : n, n == 16);
        end
        add_valid(1'b1, 8'h60, 1'b1, 8'h00, 1'b0, 0, 1'b1);

        // Asynchronous power-on reset.
        bus.in_line_start = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_column     = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ls, vecs[i].v, vecs[i].b);
            check($sformatf("v%0d valid", i), 64'(bus.out_valid), 64'(vecs[i].ev));
            if (vecs[i].ev) begin
                check($sformatf("v%0d reset", i), 64'(bus.out_reset), 64'(vecs[i].er));
                check($sformatf("v%0d col", i), 64'(bus.out_column), 64'(rep(vecs[i].b)));
                check($sformatf("v%0d peek", i), 64'(bus.out_peek_column), 64'(rep(vecs[i].ep)));
                check($sformatf("v%0d full", i), 64'(bus.out_window_full), 64'(vecs[i].ef));
                check($sformatf("v%0d idx", i), 64'(bus.out_col_index), 64'(vecs[i].ei));
                check($sformatf("v%0d ovf", i), 64'(bus.out_overflow), 64'(vecs[i].eo));
            end
        end

        // Mid-stream reset. Outputs clear between clock edges, and the block
        // stays idle until the next line start.
        step(1'b0, 1'b1, 8'h61);
        check("pre-rst valid", 64'(bus.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 8'h70);
        check("post-rst drop", 64'(bus.out_valid), 64'd0);
        step(1'b1, 1'b1, 8'h5A);
        check("post-rst valid", 64'(bus.out_valid), 64'd1);
        check("post-rst reset", 64'(bus.out_reset), 64'd1);
        check("post-rst idx", 64'(bus.out_col_index), 64'd0);
        check("post-rst col", 64'(bus.out_column), 64'(rep(8'h5A)));
        check("post-rst ovf", 64'(bus.out_overflow), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/column_window_sequencer.md
# column_window_sequencer

Front-end controller for the sliding-window moment datapaths (YMoment and siblings). It accepts a stream of pixel columns with sparse valid strobes and keeps the last `WINDOW_SIZE_X` valid columns in a ring buffer. For each valid column it presents the matched pair the moment accumulators consume: the new entering column and the "peek" column leaving the window, plus a per-line window reset. It replaces ad-hoc peek-pointer arithmetic upstream: invalid columns are skipped, and the peek is always exactly `WINDOW_SIZE_X` valid columns back.

## Interface
- `LUMA_BITS`, 8, bits per pixel
- `WINDOW_SIZE_X`, 7, window width in valid columns (≥2)
- `WINDOW_SIZE_Y`, 5, pixels per column
- `MAX_LINE_WIDTH`, 1024, maximum valid columns per line (sizes index counter)

Ports (`CW = $clog2(MAX_LINE_WIDTH)`):
- `clk`  in  1  sole clock, rising edge
- `in_reset_n`  in  1  reset, asynchronous, active-low
- `in_line_start`  in  1  next valid column is first of a new line
- `in_valid`  in  1  `in_column` carries a valid column this cycle
- `in_column`  in  `LUMA_BITS` × `WINDOW_SIZE_Y`  incoming column
- `out_valid`  out  1  output column pair valid
- `out_reset`  out  1  accompanies first valid column of a line; downstream clears accumulators
- `out_column`  out  `LUMA_BITS` × `WINDOW_SIZE_Y`  entering column
- `out_peek_column`  out  `LUMA_BITS` × `WINDOW_SIZE_Y`  leaving column; all zeros while filling
- `out_window_full`  out  1  window holds `WINDOW_SIZE_X` valid columns, including the current one
- `out_col_index`  out  `CW`  zero-based valid-column index within the line
- `out_overflow`  out  1  sticky; line exceeded `MAX_LINE_WIDTH`

## Operation
- State: ring `buf[WINDOW_SIZE_X]` of columns, `wr_ptr` (0..`WINDOW_SIZE_X`-1), `fill` (0..`WINDOW_SIZE_X`, saturating), `idx`, `pend_start`, FSM.
- FSM states:
  - IDLE: entered at reset. Valid columns are dropped, with `out_valid`=0. Leaves on the first line start.
  - FILL: `fill` < `WINDOW_SIZE_X`.
  - STEADY: `fill` = `WINDOW_SIZE_X`.
- Line start is effective when `in_line_start`=1, or when `pend_start`=1, coinciding with `in_valid`=1:
  - `wr_ptr` ← 1, `fill` ← 1, `idx` ← 0.
  - `buf[0]` ← column.
  - Emit `out_reset`=1, with `out_peek_column`=0.
  - `pend_start` clears; state → FILL (or STEADY if `WINDOW_SIZE_X`=1, not supported).
- `in_line_start`=1 with `in_valid`=0: set `pend_start`; the FSM state is unchanged until the next valid column.
- Valid column, not a line start:
  - Peek: if `fill` = `WINDOW_SIZE_X`, peek = `buf[wr_ptr]` read before the write; otherwise peek = 0.
  - Write `buf[wr_ptr]` ← column.
  - `wr_ptr` wraps from `WINDOW_SIZE_X`-1 to 0.
  - `fill` increments, saturating.
  - `idx` increments, saturating at `MAX_LINE_WIDTH`-1. On saturation, set `out_overflow`.
  - FILL → STEADY when the new `fill` reaches `WINDOW_SIZE_X`.
- `in_valid`=0: no ring, pointer, fill or index change; `out_valid`=0. Data outputs hold their last values.
- `out_window_full` = (`fill` after the update = `WINDOW_SIZE_X`).
- Ring contents are not cleared at line start; the zero peek during FILL masks stale data.
- `out_overflow` clears only on reset.

## Timing
- All outputs registered; latency is 1 cycle from an input cycle to its output pair.
- Throughput is one column per cycle, with no backpressure.
- Values after `in_reset_n` assertion (asynchronous) and held until the first clock after deassertion:
  - `out_valid`=0, `out_reset`=0, `out_window_full`=0, `out_overflow`=0.
  - `out_column`=0, `out_peek_column`=0, `out_col_index`=0.
  - FSM=IDLE, `wr_ptr`=0, `fill`=0, `pend_start`=0.
  - Ring contents: don't-care.
- Reset mid-line: the line is abandoned and the block returns to IDLE. Output resumes only after the next line start.
- `in_line_start` coinciding with a valid column while in STEADY: the new line wins. The peek is 0 and the old window is discarded.
- Peek for the k-th valid column of a line, with k ≥ `WINDOW_SIZE_X`: equals the column (k − `WINDOW_SIZE_X`), independent of how many invalid cycles lie between them.

## Test plan
Defaults apply (X=7, Y=5).

1. **Reset.** Assert `in_reset_n`=0 mid-stream, asynchronously → all outputs 0 within the same cycle. Valid columns before any `in_line_start` → `out_valid` stays 0.
2. **Fill then steady.** Line start, then 10 back-to-back valid columns where column n has all pixels = n+1.
   - Outputs 0–6: peek 0, `out_window_full`=0 except at output 6.
   - Outputs 7–9: peek = 1, 2, 3.
   - `out_reset` high only on output 0; `out_col_index` runs 0..9.
3. **Invalid gaps.** Same stream with `in_valid`=0 at input cycles 3, 7, 11.
   - Those cycles give `out_valid`=0.
   - The 8th valid column (value 8) gets peek = 1.
   - `wr_ptr` and `fill` do not advance on gap cycles.
4. **Deferred line start.** Line start pulse with `in_valid`=0, then 2 idle cycles, then valid column 0x22 → one output with `out_reset`=1, `out_col_index`=0, peek 0.
5. **Line change in STEADY.** After 9 columns, a line start with valid column 0xAA → `out_reset`=1, peek 0, `out_window_full`=0. The next 6 valid outputs also give peek 0.
6. **Overflow.** With `MAX_LINE_WIDTH`=16, feed 17 valid columns → `out_col_index` saturates at 15 and `out_overflow`=1 stays set across the next line start.
